// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive and transmit paths.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_rx_state_t;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned uart_div(input int unsigned clock_hz,
                                           input int unsigned bps,
                                           input int unsigned oversample);
    int unsigned den;
    den = bps * oversample;
    return (clock_hz + den / 2) / den;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is taken only alongside a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LOG2  = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << LOG2;

  logic [LOG2:0]      wr_ptr;
  logic [LOG2:0]      rd_ptr;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic               do_push;
  logic               do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[LOG2] != rd_ptr[LOG2]) &&
                   (wr_ptr[LOG2-1:0] == rd_ptr[LOG2-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[LOG2-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[LOG2-1:0]] <= push_data;
        wr_ptr                <= wr_ptr + (LOG2+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (LOG2+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, feeding a show-ahead byte FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned BPS       = 115200,
  parameter int unsigned CLOCK_HZ  = 48000000,
  parameter int unsigned FIFO_LOG2 = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       frame_error,
  output logic       overrun
);

  localparam int unsigned DIV      = uart_div(CLOCK_HZ, BPS, UART_OVERSAMPLE);
  localparam int unsigned PW       = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned TW       = $clog2(UART_OVERSAMPLE);
  localparam logic [TW-1:0] T_MID  = TW'(UART_OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(UART_OVERSAMPLE - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_rx_fifo: CLOCK_HZ too low for 16x oversampling at BPS");
  end

  logic [1:0]     sync;
  logic           rx_s;
  logic [PW-1:0]  presc;
  logic           tick_c;
  logic           presc_clr_c;

  uart_rx_state_t state, state_next;
  logic [TW-1:0]  tick_cnt, tick_cnt_next;
  logic [2:0]     bit_idx, bit_idx_next;
  logic [7:0]     shift, shift_next;
  logic           push_c;
  logic           ferr_c;
  logic           pop_c;
  logic           fifo_full;
  logic           fifo_empty;

  assign rx_s   = sync[1];
  assign tick_c = (presc == PW'(DIV - 1));

  // Synchronizer and prescaler; prescaler realigns to each detected start edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= 2'b11;
      presc <= '0;
    end else begin
      sync <= {sync[0], rx};
      if (presc_clr_c || tick_c) presc <= '0;
      else                       presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      tick_cnt    <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_next;
      tick_cnt    <= tick_cnt_next;
      bit_idx     <= bit_idx_next;
      shift       <= shift_next;
      frame_error <= ferr_c;
      overrun     <= push_c && fifo_full && !pop_c;
    end
  end

  always_comb begin
    state_next    = state;
    tick_cnt_next = tick_cnt;
    bit_idx_next  = bit_idx;
    shift_next    = shift;
    push_c        = 1'b0;
    ferr_c        = 1'b0;
    presc_clr_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_next    = ST_START;
          tick_cnt_next = '0;
          presc_clr_c   = 1'b1;
        end
      end
      ST_START: begin
        if (tick_c) begin
          tick_cnt_next = tick_cnt + TW'(1);
          if (tick_cnt == T_MID) begin
            tick_cnt_next = '0;
            bit_idx_next  = '0;
            state_next    = rx_s ? ST_IDLE : ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          tick_cnt_next = tick_cnt + TW'(1);
          if (tick_cnt == T_LAST) begin
            shift_next[bit_idx] = rx_s;
            bit_idx_next        = bit_idx + 3'd1;
            if (bit_idx == 3'd7) state_next = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (tick_c) begin
          tick_cnt_next = tick_cnt + TW'(1);
          if (tick_cnt == T_LAST) begin
            if (rx_s) begin
              push_c     = 1'b1;
              state_next = ST_IDLE;
            end else begin
              ferr_c     = 1'b1;
              state_next = ST_WAIT_HIGH;
            end
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign rx_valid = !fifo_empty;
  assign pop_c    = rx_valid && rx_ready;

  sync_fifo #(
    .WIDTH (8),
    .LOG2  (FIFO_LOG2)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push_c),
    .push_data (shift),
    .pop       (pop_c),
    .head      (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed frames in, monitor compares every accepted byte.
module tb_uart_rx_fifo;

  localparam int unsigned BPS      = 115200;
  localparam int unsigned CLOCK_HZ = 7372800;   // 4 clocks per tick, 64 per bit
  localparam int          BIT      = 64;
  localparam int          BIT_SLOW = 66;        // about +3 % bit period
  localparam int          BIT_FAST = 62;        // about -3 % bit period

  logic       clock = 1'b0;
  logic       reset_n;
  logic       rx;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       frame_error;
  logic       overrun;

  int tests = 0;
  int fails = 0;
  int n_acc = 0;
  int n_valid = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic fe_prev = 1'b0;
  logic ov_prev = 1'b0;
  logic [7:0] sb[$];

  always #5 clock = ~clock;

  uart_rx_fifo #(
    .BPS       (BPS),
    .CLOCK_HZ  (CLOCK_HZ),
    .FIFO_LOG2 (4)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx          (rx),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int bclk, input logic stop_bit);
    rx = 1'b0;
    cycles(bclk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(bclk);
    end
    rx = stop_bit;
    cycles(bclk);
    rx = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every accepted byte and tracks error pulses.
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clock);
      if (reset_n === 1'b1) begin
        if (rx_valid) n_valid++;
        if (rx_valid && rx_ready) begin
          n_acc++;
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_byte: got %02h, none expected (t=%0t)", rx_data, $time);
          end else begin
            exp = sb.pop_front();
            check("rx_data", 32'(rx_data), 32'(exp));
          end
        end
        if (frame_error) begin
          fe_cnt++;
          check("frame_error_single_cycle", 32'(fe_prev), 32'd0);
        end
        if (overrun) begin
          ov_cnt++;
          check("overrun_single_cycle", 32'(ov_prev), 32'd0);
        end
      end
      fe_prev = frame_error;
      ov_prev = overrun;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    int acc0;
    int val0;
    reset_n  = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b0;
    cycles(5);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    check("reset_frame_error", 32'(frame_error), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    cycles(BIT);

    // Single byte with consumer ready.
    rx_ready = 1'b1;
    acc0 = n_acc;
    val0 = n_valid;
    sb.push_back(8'h55);
    send_byte(8'h55, BIT, 1'b1);
    cycles(BIT);
    check("single_accepted", 32'(n_acc - acc0), 32'd1);
    check("single_valid_cycles", 32'(n_valid - val0), 32'd1);
    check("single_no_errors", 32'(fe_cnt + ov_cnt), 32'd0);

    // Buffering: three bytes queued, then drained on consecutive cycles.
    rx_ready = 1'b0;
    foreach (sb[i]) check("sb_clean", 32'd1, 32'd0);
    sb.push_back(8'h00); send_byte(8'h00, BIT, 1'b1);
    sb.push_back(8'hFF); send_byte(8'hFF, BIT, 1'b1);
    sb.push_back(8'hA5); send_byte(8'hA5, BIT, 1'b1);
    cycles(10);
    check("buf_valid_before_ready", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("buf_valid_consecutive", 32'(rx_valid), 32'd1);
    end
    @(negedge clock);
    check("buf_valid_after_drain", 32'(rx_valid), 32'd0);
    check("buf_sb_empty", 32'(sb.size()), 32'd0);
    cycles(2);

    // Overrun: 17 bytes into a 16-deep FIFO.
    rx_ready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      if (i <= 16) sb.push_back(8'(i));
      send_byte(8'(i), BIT, 1'b1);
      if (i == 16) check("overrun_none_at_16", 32'(ov_cnt), 32'd0);
    end
    cycles(5);
    check("overrun_one_pulse", 32'(ov_cnt), 32'd1);
    rx_ready = 1'b1;
    cycles(30);
    check("overrun_drain_empty", 32'(sb.size()), 32'd0);
    check("overrun_valid_low", 32'(rx_valid), 32'd0);

    // Framing error with line held low, then a clean frame.
    acc0 = n_acc;
    send_byte(8'h3C, BIT, 1'b0);
    rx = 1'b0;
    cycles(3 * BIT);
    rx = 1'b1;
    cycles(2 * BIT);
    check("frame_error_one_pulse", 32'(fe_cnt), 32'd1);
    check("frame_error_nothing_queued", 32'(n_acc - acc0), 32'd0);
    sb.push_back(8'h3C);
    send_byte(8'h3C, BIT, 1'b1);
    cycles(BIT);
    check("frame_recover_sb_empty", 32'(sb.size()), 32'd0);

    // Glitch shorter than half a bit.
    acc0 = n_acc;
    rx = 1'b0;
    cycles(20);
    rx = 1'b1;
    cycles(12 * BIT);
    check("glitch_no_byte", 32'(n_acc - acc0), 32'd0);
    check("glitch_no_error", 32'(fe_cnt), 32'd1);

    // Rate tolerance and back-to-back frames with a single stop bit.
    sb.push_back(8'hC3); send_byte(8'hC3, BIT_SLOW, 1'b1);
    sb.push_back(8'hC3); send_byte(8'hC3, BIT_FAST, 1'b1);
    sb.push_back(8'h5A); send_byte(8'h5A, BIT_FAST, 1'b1);
    sb.push_back(8'h5A); send_byte(8'h5A, BIT_FAST, 1'b1);
    cycles(BIT);
    check("rate_sb_empty", 32'(sb.size()), 32'd0);
    check("rate_no_errors", 32'(fe_cnt + ov_cnt), 32'd2);

    // Reset during bit 4 with two bytes queued.
    rx_ready = 1'b0;
    sb.push_back(8'h11); send_byte(8'h11, BIT, 1'b1);
    sb.push_back(8'h22); send_byte(8'h22, BIT, 1'b1);
    cycles(5);
    check("pre_reset_valid", 32'(rx_valid), 32'd1);
    rx = 1'b0;
    cycles(5 * BIT + BIT / 2);
    reset_n = 1'b0;
    #1;
    check("mid_reset_valid", 32'(rx_valid), 32'd0);
    check("mid_reset_data", 32'(rx_data), 32'd0);
    sb.delete();
    rx = 1'b1;
    cycles(5);
    reset_n = 1'b1;
    cycles(12 * BIT);
    check("post_reset_valid", 32'(rx_valid), 32'd0);
    rx_ready = 1'b1;
    acc0 = n_acc;
    sb.push_back(8'h81);
    send_byte(8'h81, BIT, 1'b1);
    cycles(BIT);
    check("post_reset_accepted", 32'(n_acc - acc0), 32'd1);
    check("post_reset_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
